// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: state encodings,
// default timing constants, the BCD time payload and its decrement helper.
package timer_pkg;

  // State encodings (3-bit, codes 5-7 unused)
  localparam logic [2:0] ST_OCIOSO   = 3'd0;
  localparam logic [2:0] ST_CARGA    = 3'd1;
  localparam logic [2:0] ST_CONTANDO = 3'd2;
  localparam logic [2:0] ST_PAUSA    = 3'd3;
  localparam logic [2:0] ST_FIM      = 3'd4;

  localparam int unsigned DIV_DEFAULT    = 50_000_000;
  localparam int unsigned ATRASO_DEFAULT = 4;

  // Four BCD digits MM:SS
  typedef struct packed {
    logic [3:0] min_d;
    logic [3:0] min_u;
    logic [3:0] sec_d;
    logic [3:0] sec_u;
  } tempo_t;

  // One-second BCD decrement; 00:00 stays 00:00. Seconds tens above 5
  // (entered 60-99) simply count down through the tens digit.
  function automatic tempo_t bcd_dec(input tempo_t t);
    tempo_t r;
    r = t;
    if (t.sec_u != 4'd0) begin
      r.sec_u = t.sec_u - 4'd1;
    end else if (t.sec_d != 4'd0) begin
      r.sec_d = t.sec_d - 4'd1;
      r.sec_u = 4'd9;
    end else if (t.min_u != 4'd0) begin
      r.min_u = t.min_u - 4'd1;
      r.sec_d = 4'd5;
      r.sec_u = 4'd9;
    end else if (t.min_d != 4'd0) begin
      r.min_d = t.min_d - 4'd1;
      r.min_u = 4'd9;
      r.sec_d = 4'd5;
      r.sec_u = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/controle_timer_mux.sv
// Strobe selector: forwards the delayed load strobe while loading and the
// 1 Hz tick while counting.
//   sel          in  1 : 1 selects saida_atraso, 0 selects hz_tick
//   saida_atraso in  1 : delayed load strobe
//   hz_tick      in  1 : 1 Hz tick
//   pulso        out 1 : selected strobe (combinational)
module mux (
  input  logic sel,
  input  logic saida_atraso,
  input  logic hz_tick,
  output logic pulso
);

  assign pulso = sel ? saida_atraso : hz_tick;

endmodule

// File: rtl/controle_timer.sv
// Keypad-loaded MM:SS countdown timer with pause, clear and a delayed
// load strobe.
//   clock, reset_n          : system clock, async active-low reset
//   tecla[3:0], tecla_valida: keypad digit and its one-cycle strobe
//   iniciar, pausar, limpar : one-cycle command strobes
//   min_d..sec_u[3:0]       : BCD time digits
//   sel, saida_atraso       : mux select, delayed one-cycle load strobe
//   hz_tick, pulso          : 1 Hz tick, muxed strobe
//   fim, estado[2:0]        : countdown done, current state
module controle_timer
  import timer_pkg::*;
#(
  parameter int unsigned DIV    = DIV_DEFAULT,
  parameter int unsigned ATRASO = ATRASO_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] tecla,
  input  logic       tecla_valida,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       limpar,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [3:0] sec_d,
  output logic [3:0] sec_u,
  output logic       sel,
  output logic       saida_atraso,
  output logic       hz_tick,
  output logic       pulso,
  output logic       fim,
  output logic [2:0] estado
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned AW = (ATRASO > 2) ? $clog2(ATRASO) : 1;

  logic [2:0]    estado_q, estado_d, st;
  tempo_t        tempo_q, tempo_d, tempo_dec;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] atraso_q, atraso_d;
  logic          saida_q, saida_d;
  logic          hz_q, hz_d;
  logic          sel_q, sel_d;
  logic          fim_q, fim_d;
  logic          carregando;

  // Next-state, digit, prescaler and delay logic
  always_comb begin
    st         = (estado_q > ST_FIM) ? ST_OCIOSO : estado_q;
    estado_d   = st;
    tempo_d    = tempo_q;
    presc_d    = presc_q;
    atraso_d   = atraso_q;
    saida_d    = (atraso_q == AW'(1));
    tempo_dec  = bcd_dec(tempo_q);
    carregando = (st == ST_OCIOSO) || (st == ST_CARGA);

    if (atraso_q != '0) begin
      atraso_d = atraso_q - AW'(1);
    end

    // Free-running countdown; commands below may override it
    if (st == ST_CONTANDO) begin
      if (presc_q == PW'(DIV - 1)) begin
        presc_d = '0;
        tempo_d = tempo_dec;
        if (tempo_dec == '0) begin
          estado_d = ST_FIM;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (limpar) begin
      estado_d = ST_OCIOSO;
      tempo_d  = '0;
      presc_d  = '0;
      atraso_d = '0;
      saida_d  = 1'b0;
    end else if (iniciar) begin
      if (carregando && (tempo_q != '0)) begin
        estado_d = ST_CONTANDO;
        presc_d  = '0;
        atraso_d = '0;
        saida_d  = 1'b0;
      end
    end else if (pausar) begin
      // Toggle cycle itself does not advance the prescaler
      if (st == ST_CONTANDO) begin
        estado_d = ST_PAUSA;
        presc_d  = presc_q;
        tempo_d  = tempo_q;
      end else if (st == ST_PAUSA) begin
        estado_d = ST_CONTANDO;
      end
    end else if (tecla_valida) begin
      if (carregando && (tecla <= 4'd9)) begin
        estado_d      = ST_CARGA;
        tempo_d.min_d = tempo_q.min_u;
        tempo_d.min_u = tempo_q.sec_d;
        tempo_d.sec_d = tempo_q.sec_u;
        tempo_d.sec_u = tecla;
        // Counter holds ATRASO-1 so the pulse lands ATRASO cycles after the key
        atraso_d      = AW'(ATRASO - 1);
        saida_d       = (ATRASO == 1);
      end
    end

    hz_d  = (estado_d == ST_CONTANDO) && (presc_d == PW'(DIV - 1));
    sel_d = (estado_d == ST_OCIOSO) || (estado_d == ST_CARGA);
    fim_d = (estado_d == ST_FIM);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= ST_OCIOSO;
      tempo_q  <= '0;
      presc_q  <= '0;
      atraso_q <= '0;
      saida_q  <= 1'b0;
      hz_q     <= 1'b0;
      sel_q    <= 1'b1;
      fim_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      tempo_q  <= tempo_d;
      presc_q  <= presc_d;
      atraso_q <= atraso_d;
      saida_q  <= saida_d;
      hz_q     <= hz_d;
      sel_q    <= sel_d;
      fim_q    <= fim_d;
    end
  end

  assign min_d        = tempo_q.min_d;
  assign min_u        = tempo_q.min_u;
  assign sec_d        = tempo_q.sec_d;
  assign sec_u        = tempo_q.sec_u;
  assign estado       = estado_q;
  assign saida_atraso = saida_q;
  assign hz_tick      = hz_q;
  assign sel          = sel_q;
  assign fim          = fim_q;

  mux u_mux (
    .sel          (sel_q),
    .saida_atraso (saida_q),
    .hz_tick      (hz_q),
    .pulso        (pulso)
  );

endmodule

// File: tb/tb_controle_timer.sv
// Directed bench for controle_timer with DIV=4, ATRASO=3.
module tb_controle_timer;

  logic       clock;
  logic       reset_n;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       iniciar;
  logic       pausar;
  logic       limpar;
  logic [3:0] min_d, min_u, sec_d, sec_u;
  logic       sel, saida_atraso, hz_tick, pulso, fim;
  logic [2:0] estado;
  logic [15:0] tempo;

  int n_cmp = 0;
  int n_err = 0;

  assign tempo = {min_d, min_u, sec_d, sec_u};

  controle_timer #(.DIV(4), .ATRASO(3)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .iniciar      (iniciar),
    .pausar       (pausar),
    .limpar       (limpar),
    .min_d        (min_d),
    .min_u        (min_u),
    .sec_d        (sec_d),
    .sec_u        (sec_u),
    .sel          (sel),
    .saida_atraso (saida_atraso),
    .hz_tick      (hz_tick),
    .pulso        (pulso),
    .fim          (fim),
    .estado       (estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    tecla        = k;
    tecla_valida = 1'b1;
    tick();
    tecla_valida = 1'b0;
  endtask

  task automatic cmd_limpar();
    limpar = 1'b1;
    tick();
    limpar = 1'b0;
  endtask

  task automatic cmd_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic cmd_pausar();
    pausar = 1'b1;
    tick();
    pausar = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_estado"}, 16'(estado), 16'd0);
    chk({tag, "_tempo"},  tempo, 16'h0000);
    chk({tag, "_sel"},    16'(sel), 16'd1);
    chk({tag, "_saida"},  16'(saida_atraso), 16'd0);
    chk({tag, "_hz"},     16'(hz_tick), 16'd0);
    chk({tag, "_pulso"},  16'(pulso), 16'd0);
    chk({tag, "_fim"},    16'(fim), 16'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    tecla        = 4'd0;
    tecla_valida = 1'b0;
    iniciar      = 1'b0;
    pausar       = 1'b0;
    limpar       = 1'b0;
    #12;
    chk_reset_vals("rst");
    #10 reset_n = 1'b1;
    tick();

    // Keys 1,3,0 -> 01:30, single delayed pulse for the last key only
    press(4'd1);
    press(4'd3);
    press(4'd0);
    chk("k_tempo", tempo, 16'h0130);
    chk("k_estado", 16'(estado), 16'd1);
    chk("k_saida_c1", 16'(saida_atraso), 16'd0);
    tick();
    chk("k_saida_c2", 16'(saida_atraso), 16'd0);
    tick();
    chk("k_saida_c3", 16'(saida_atraso), 16'd1);
    chk("k_pulso_c3", 16'(pulso), 16'd1);
    chk("k_sel", 16'(sel), 16'd1);
    tick();
    chk("k_saida_c4", 16'(saida_atraso), 16'd0);
    chk("k_pulso_c4", 16'(pulso), 16'd0);

    // 00:02 countdown to FIM; iniciar cancels the pending load pulse
    cmd_limpar();
    chk("clr_tempo", tempo, 16'h0000);
    press(4'd0);
    press(4'd2);
    chk("c2_tempo", tempo, 16'h0002);
    cmd_iniciar();
    chk("c2_estado", 16'(estado), 16'd2);
    chk("c2_sel", 16'(sel), 16'd0);
    chk("c2_hz1", 16'(hz_tick), 16'd0);
    tick();
    chk("c2_cancel", 16'(saida_atraso), 16'd0);
    chk("c2_hz2", 16'(hz_tick), 16'd0);
    tick();
    chk("c2_hz3", 16'(hz_tick), 16'd0);
    tick();
    chk("c2_hz4", 16'(hz_tick), 16'd1);
    chk("c2_pulso4", 16'(pulso), 16'd1);
    chk("c2_tempo4", tempo, 16'h0002);
    tick();
    chk("c2_tempo5", tempo, 16'h0001);
    chk("c2_hz5", 16'(hz_tick), 16'd0);
    tick();
    tick();
    tick();
    chk("c2_hz8", 16'(hz_tick), 16'd1);
    tick();
    chk("c2_tempo9", tempo, 16'h0000);
    chk("c2_estado9", 16'(estado), 16'd4);
    chk("c2_fim9", 16'(fim), 16'd1);
    cmd_iniciar();
    tick();
    tick();
    chk("fim_hold", 16'(fim), 16'd1);
    chk("fim_estado", 16'(estado), 16'd4);
    chk("fim_sel", 16'(sel), 16'd0);
    chk("fim_hz", 16'(hz_tick), 16'd0);
    chk("fim_tempo", tempo, 16'h0000);

    // 01:00 -> 00:59 (minute borrow)
    cmd_limpar();
    press(4'd0);
    press(4'd1);
    press(4'd0);
    press(4'd0);
    chk("b_load", tempo, 16'h0100);
    cmd_iniciar();
    repeat (4) tick();
    chk("b_tempo", tempo, 16'h0059);

    // 00:95 -> 00:94
    cmd_limpar();
    press(4'd9);
    press(4'd5);
    cmd_iniciar();
    repeat (4) tick();
    chk("s95_tempo", tempo, 16'h0094);

    // Pause freezes prescaler and digits
    cmd_limpar();
    press(4'd5);
    cmd_iniciar();
    tick();
    cmd_pausar();
    chk("p_estado", 16'(estado), 16'd3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("p_hz", 16'(hz_tick), 16'd0);
      chk("p_tempo", tempo, 16'h0005);
    end
    chk("p_estado_end", 16'(estado), 16'd3);
    cmd_pausar();
    chk("r_estado", 16'(estado), 16'd2);
    chk("r_hz1", 16'(hz_tick), 16'd0);
    tick();
    chk("r_hz2", 16'(hz_tick), 16'd0);
    tick();
    chk("r_hz3", 16'(hz_tick), 16'd1);
    tick();
    chk("r_tempo", tempo, 16'h0004);

    // iniciar with 00:00 is ignored
    cmd_limpar();
    cmd_iniciar();
    chk("z_estado", 16'(estado), 16'd0);
    chk("z_sel", 16'(sel), 16'd1);

    // Invalid key ignored, and does not restart a pending delay
    press(4'hA);
    chk("a_tempo", tempo, 16'h0000);
    chk("a_estado", 16'(estado), 16'd0);
    press(4'd7);
    press(4'hA);
    chk("a2_saida", 16'(saida_atraso), 16'd0);
    tick();
    chk("a2_saida3", 16'(saida_atraso), 16'd1);
    chk("a2_tempo", tempo, 16'h0007);

    // limpar wins over iniciar in the same cycle
    limpar  = 1'b1;
    iniciar = 1'b1;
    tick();
    limpar  = 1'b0;
    iniciar = 1'b0;
    chk("li_estado", 16'(estado), 16'd0);
    chk("li_tempo", tempo, 16'h0000);

    // Asynchronous reset while a tick is high
    press(4'd3);
    cmd_iniciar();
    repeat (3) tick();
    chk("ar_hz_pre", 16'(hz_tick), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("ar");
    #2 reset_n = 1'b1;
    tick();
    chk("ar_post_estado", 16'(estado), 16'd0);
    press(4'd2);
    chk("ar_post_tempo", tempo, 16'h0002);
    chk("ar_post_carga", 16'(estado), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controle_timer.md
CONTROLE_TIMER -- requirements
Module: controle_timer

Interface
REQ-001 Parameters: DIV, default 50_000_000, clock cycles per 1 Hz tick (>=2); ATRASO, default 4, cycles from accepted key to load strobe (>=1).
REQ-002 clock  in  1  system clock, all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 tecla  in  4  keypad digit, valid when tecla_valida=1.
REQ-005 tecla_valida  in  1  one-cycle key strobe.
REQ-006 iniciar, pausar, limpar  in  1 each  one-cycle command strobes.
REQ-007 min_d, min_u, sec_d, sec_u  out  4 each  BCD time digits MM:SS.
REQ-008 sel  out  1  mux select: 1 selects saida_atraso, 0 selects hz_tick.
REQ-009 saida_atraso  out  1  delayed one-cycle load strobe.
REQ-010 hz_tick  out  1  one-cycle 1 Hz tick.
REQ-011 pulso  out  1  muxed strobe: sel ? saida_atraso : hz_tick.
REQ-012 fim  out  1  countdown reached 00:00.
REQ-013 estado  out  3  current state encoding.

Function
REQ-014 States/encoding: OCIOSO=0, CARGA=1, CONTANDO=2, PAUSA=3, FIM=4; values 5-7 unreachable, treated as OCIOSO.
REQ-015 Command priority per cycle: limpar > iniciar > pausar > tecla_valida; lower-priority strobes in the same cycle are dropped.
REQ-016 limpar in any state: next state OCIOSO, all digits 0, prescaler and delay counter cleared, fim=0.
REQ-017 tecla_valida with tecla<=9 in OCIOSO or CARGA: next state CARGA; digits shift left (min_d<=min_u, min_u<=sec_d, sec_d<=sec_u, sec_u<=tecla), visible next cycle.
REQ-018 tecla>9, or key in CONTANDO/PAUSA/FIM: ignored, no delay restart.
REQ-019 Accepted key loads delay counter; saida_atraso high exactly one cycle, ATRASO cycles after the strobe cycle; a new accepted key restarts the delay (single pulse for the latest key).
REQ-020 iniciar in OCIOSO/CARGA with nonzero digits: next state CONTANDO, prescaler cleared, pending saida_atraso cancelled; with all digits 0: ignored.
REQ-021 CONTANDO: prescaler counts 0..DIV-1 and wraps; hz_tick=1 while prescaler==DIV-1, so first tick DIV cycles after entry.
REQ-022 On each hz_tick edge digits decrement: sec_u>0 -> sec_u-1; else sec_d>0 -> sec_d-1, sec_u=9; else minutes>0 -> borrow one minute (BCD), sec=59; applies to entered seconds 60-99 too.
REQ-023 Decrement yielding 00:00: next state FIM, fim=1 from next cycle until limpar.
REQ-024 pausar toggles CONTANDO<->PAUSA; in PAUSA prescaler and digits frozen, hz_tick=0; resume continues from frozen prescaler value.
REQ-025 pausar in OCIOSO/CARGA/FIM and iniciar in CONTANDO/PAUSA/FIM: ignored.
REQ-026 sel=1 in OCIOSO/CARGA, sel=0 in CONTANDO/PAUSA/FIM; sel, fim, estado registered; pulso combinational from registered sel/strobes.
REQ-027 Digits never leave BCD range; no decrement below 00:00.

Reset
REQ-028 reset_n=0 asynchronously forces: estado=OCIOSO, digits 0, sel=1, saida_atraso=0, hz_tick=0, pulso=0, fim=0, prescaler and delay counters 0.
REQ-029 Reset mid-count or mid-delay discards all progress; first edge after release behaves as from OCIOSO.

Structure
REQ-030 State encodings and default DIV/ATRASO constants in shared package timer_pkg.
REQ-031 pulso produced by one instance of existing sub-module mux (sel, saida_atraso, hz_tick -> pulso); BCD decrement may be a function in timer_pkg.

Verification (DIV=4, ATRASO=3)
REQ-032 Reset then keys 1,3,0 -> digits 01:30 after third key, saida_atraso and pulso single pulse 3 cycles after last key only, sel=1.
REQ-033 Load 00:02, iniciar -> hz_tick every 4 cycles, digits 00:01 then 00:00, estado=FIM, fim=1 held, sel=0.
REQ-034 Load 01:00, iniciar, one tick -> 00:59; load 00:95, iniciar, one tick -> 00:94.
REQ-035 CONTANDO 00:05, pausar 10 cycles, pausar -> no tick or decrement during PAUSA, next tick at remaining prescaler count.
REQ-036 iniciar with 00:00 -> stays OCIOSO; limpar+iniciar same cycle -> OCIOSO, digits 0; key 0xA -> ignored.
REQ-037 reset_n low mid-CONTANDO (asynchronous to clock) -> all outputs at reset values immediately.
